// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute/mem/writeback sequencer owning the PC and commit strobes
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          CNT_WIDTH   = 32,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 halt_req,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 branch_taken,
    input  logic                 mem_read_req,
    input  logic                 mem_write_req,
    input  logic                 reg_write_req,
    input  logic [31:0]          imm,
    input  logic                 mem_ready,
    output logic [31:0]          pc_out,
    output logic                 ir_en,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 retired,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [2:0]           state,
    output logic                 err
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        ERROR   = 3'd7
    } state_t;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        cur, nxt;
    logic [TW-1:0] tcnt;
    logic          take_q, take_c, take_now;
    logic [31:0]   target_q, target_c, target_now;
    logic          commit;

    assign take_c     = jump | (branch & branch_taken);
    assign target_c   = pc_out + imm;
    assign take_now   = (cur == EXECUTE) ? take_c : take_q;
    assign target_now = (cur == EXECUTE) ? target_c : target_q;

    always_comb begin
        nxt    = cur;
        commit = 1'b0;
        case (cur)
            IDLE:    nxt = (run && !halt_req) ? FETCH : IDLE;
            FETCH:   nxt = DECODE;
            DECODE:  nxt = EXECUTE;
            EXECUTE: begin
                if ((take_c && target_c[1:0] != 2'b00) || (mem_read_req && mem_write_req))
                    nxt = ERROR;
                else if (mem_read_req || mem_write_req)
                    nxt = MEM;
                else if (reg_write_req)
                    nxt = WB;
                else
                    commit = 1'b1;
            end
            MEM: begin
                if (mem_ready) begin
                    if (mem_read_req && reg_write_req)
                        nxt = WB;
                    else
                        commit = 1'b1;
                end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
                    nxt = ERROR;
                end
            end
            WB:      commit = 1'b1;
            ERROR:   nxt = ERROR;
            default: nxt = ERROR;
        endcase
        if (commit)
            nxt = halt_req ? IDLE : FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= IDLE;
            pc_out      <= RESET_PC;
            instr_count <= '0;
            tcnt        <= '0;
            take_q      <= 1'b0;
            target_q    <= '0;
        end else begin
            cur <= nxt;
            if (cur == EXECUTE) begin
                take_q   <= take_c;
                target_q <= target_c;
                tcnt     <= '0;
            end else if (cur == MEM && !mem_ready) begin
                tcnt <= tcnt + TW'(1);
            end
            if (commit) begin
                pc_out      <= take_now ? target_now : pc_out + 32'd4;
                instr_count <= instr_count + CNT_WIDTH'(1);
            end
        end
    end

    assign state     = cur;
    assign ir_en     = cur == FETCH;
    assign mem_read  = (cur == MEM) && mem_read_req;
    assign mem_write = (cur == MEM) && mem_write_req;
    assign reg_write = cur == WB;
    assign retired   = commit;
    assign err       = cur == ERROR;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, run, halt_req, branch, jump, branch_taken;
    logic        mem_read_req, mem_write_req, reg_write_req, mem_ready;
    logic [31:0] imm, pc_out;
    logic        ir_en, mem_read, mem_write, reg_write, retired, err;
    logic [3:0]  instr_count;
    logic [2:0]  state;

    pc_sequencer #(.RESET_PC(32'h0), .CNT_WIDTH(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
        .branch(branch), .jump(jump), .branch_taken(branch_taken),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .reg_write_req(reg_write_req), .imm(imm), .mem_ready(mem_ready),
        .pc_out(pc_out), .ir_en(ir_en), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .retired(retired), .instr_count(instr_count),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cnt;
        int          lat;
        int          nrd;
        int          nwr;
        int          nrw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_m;
    logic [3:0]  cnt_m;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit br, input bit jp, input bit tk, input bit rd, input bit wr,
                         input bit rw, input logic [31:0] im);
        branch = br; jump = jp; branch_taken = tk;
        mem_read_req = rd; mem_write_req = wr; reg_write_req = rw; imm = im;
    endtask

    task automatic do_reset;
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_state", state, 3'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_cnt", instr_count, 4'd0);
        check("rst_err", err, 1'b0);
        check("rst_strobes", {ir_en, mem_read, mem_write, reg_write, retired}, 5'd0);
        pc_m = 32'h0; cnt_m = 4'd0; sb.delete();
    endtask

    task automatic issue(input bit br, input bit jp, input bit tk, input bit rd, input bit wr,
                         input bit rw, input logic [31:0] im, input int wt, input bit hlt);
        exp_t e;
        bit   take, done;
        int   mc, cyc, n_ir, n_rd, n_wr, n_rw;
        drive(br, jp, tk, rd, wr, rw, im);
        halt_req = hlt; run = 1'b1; mem_ready = 1'b0;
        take  = jp | (br & tk);
        e.pc  = take ? pc_m + im : pc_m + 32'd4;
        e.cnt = cnt_m + 4'd1;
        e.lat = 3 + ((rd | wr) ? wt + 1 : 0) + ((rw && !wr) ? 1 : 0);
        e.nrd = rd ? wt + 1 : 0;
        e.nwr = wr ? wt + 1 : 0;
        e.nrw = (rw && !wr) ? 1 : 0;
        sb.push_back(e);
        pc_m = e.pc; cnt_m = e.cnt;
        done = 0; mc = 0; cyc = 0; n_ir = 0; n_rd = 0; n_wr = 0; n_rw = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (state == 3'd4) begin
                mem_ready = (mc == wt);
                mc++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (state != 3'd0) cyc++;
            n_ir += int'(ir_en); n_rd += int'(mem_read);
            n_wr += int'(mem_write); n_rw += int'(reg_write);
            if (retired) done = 1;
            @(negedge clk);
            if (i == 0) run = 1'b0;
        end
        mem_ready = 1'b0;
        #1;
        check("retire_seen", done, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", cyc, e.lat);
            check("ir_en_cycles", n_ir, 1);
            check("mem_read_cycles", n_rd, e.nrd);
            check("mem_write_cycles", n_wr, e.nwr);
            check("reg_write_cycles", n_rw, e.nrw);
            check("pc_after", pc_out, e.pc);
            check("count_after", instr_count, e.cnt);
            check("next_state", state, hlt ? 3'd0 : 3'd1);
            check("err_clear", err, 1'b0);
        end
        halt_req = 1'b0;
    endtask

    task automatic issue_err(input bit br, input bit jp, input bit tk, input bit rd, input bit wr,
                             input logic [31:0] im, input int exp_mem);
        int n_m = 0;
        drive(br, jp, tk, rd, wr, 1'b0, im);
        halt_req = 1'b0; run = 1'b1; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 60 && state != 3'd7; i++) begin
            n_m += int'(mem_read | mem_write);
            @(negedge clk);
            if (i == 0) run = 1'b0;
            #1;
        end
        check("err_state", state, 3'd7);
        check("err_flag", err, 1'b1);
        check("err_pc_frozen", pc_out, pc_m);
        check("err_mem_cycles", n_m, exp_mem);
        check("err_strobes", {ir_en, mem_read, mem_write, reg_write, retired}, 5'd0);
        run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", err, 1'b1);
        check("err_pc_hold", pc_out, pc_m);
        check("err_count_hold", instr_count, cnt_m);
    endtask

    initial begin
        do_reset();
        issue(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) issue(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        issue(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 32'h0000_0100, 0, 0);
        issue(1, 1, 0, 0, 0, 1, 32'h0000_0020, 0, 0);
        issue(0, 0, 0, 1, 0, 1, 32'h0, 3, 0);
        issue(0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
        issue(0, 0, 0, 0, 1, 1, 32'h0, 2, 0);
        issue(0, 0, 0, 1, 0, 1, 32'h0, 1, 1);
        issue(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        for (int k = 0; k < 20 && cnt_m != 4'd0; k++) issue(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("count_wrap", instr_count, 4'd0);
        issue(0, 1, 0, 0, 0, 0, 32'h10 - pc_m, 0, 0);
        check("pc_at_0x10", pc_out, 32'h10);
        issue_err(1, 0, 1, 0, 0, 32'h6, 0);

        do_reset();
        issue(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        issue_err(0, 0, 0, 0, 1, 32'h0, 15);
        do_reset();
        issue_err(0, 0, 0, 1, 1, 32'h0, 0);

        do_reset();
        issue(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 32'h0);
        run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 10 && state != 3'd4; i++) @(negedge clk);
        @(negedge clk);
        #1;
        check("midmem_state", state, 3'd4);
        check("midmem_read", mem_read, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_state", state, 3'd0);
        check("abort_pc", pc_out, 32'h0);
        check("abort_cnt", instr_count, 4'd0);
        check("abort_strobes", {ir_en, mem_read, mem_write, reg_write, retired, err}, 6'd0);
        pc_m = 32'h0; cnt_m = 4'd0; sb.delete();
        issue(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
